// File: rtl/mvu_pe_simd_dot.sv
`default_nettype none
// ============================================================================
// Module   : mvu_pe_simd_dot
// Purpose  : SIMD dot-product slice for an MVAU processing element. Each
//            accepted beat multiplies SIMD activation/weight lane pairs,
//            reduces them through a registered adder tree and accumulates
//            SF beat sums into one TDstI-bit result.
// Ports    : clk            - rising-edge clock
//            rst            - synchronous active-high reset
//            do_mvau_stream - pipeline enable, low freezes all registers
//            in_v           - input beat valid
//            in_act         - SIMD activations, lane i at [i*TSrcI +: TSrcI]
//            in_wgt         - SIMD weights, lane i at [i*TW +: TW]
//            out_v          - result valid, one pulse per SF beats
//            out            - accumulated dot product
//            out_sat        - a clamp occurred during this result's fold
// Options  : MVU_PE_SIMD_SAT_EN - saturating accumulator; when undefined
//            the accumulator wraps and out_sat is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module mvu_pe_simd_dot #(
   parameter int SIMD       = 4,
   parameter int TSrcI      = 4,
   parameter int TW         = 4,
   parameter int TDstI      = 16,
   parameter int SF         = 8,
   parameter int ACT_SIGNED = 1,
   parameter int WGT_SIGNED = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  do_mvau_stream,
   input  logic                  in_v,
   input  logic [SIMD*TSrcI-1:0] in_act,
   input  logic [SIMD*TW-1:0]    in_wgt,
   output logic                  out_v,
   output logic [TDstI-1:0]      out,
   output logic                  out_sat
);

   localparam bit c_sgn   = (ACT_SIGNED != 0) || (WGT_SIGNED != 0);
   localparam bit c_mixed = (ACT_SIGNED != 0) != (WGT_SIGNED != 0);
   localparam int c_pw    = TSrcI + TW + (c_mixed ? 1 : 0);
   localparam int c_depth = (SIMD > 1) ? $clog2(SIMD) : 0;
   localparam int c_np    = 1 << c_depth;
   // Tree nodes all carry the root width; upper bits of shallow levels are
   // plain extensions, so the arithmetic equals 1-bit growth per level.
   localparam int c_sw    = c_pw + c_depth;
   // Two guard bits let the accumulate add be evaluated exactly for clamping.
   localparam int c_aw    = ((c_sw > TDstI) ? c_sw : TDstI) + 2;
   localparam int c_cw    = (SF > 1) ? $clog2(SF) : 1;
   localparam logic [c_cw-1:0] c_last = c_cw'(SF - 1);

   // Heap-ordered tree: node k sums nodes 2k and 2k+1, leaves at c_np..2*c_np-1,
   // root at 1. With SIMD=1 the single leaf is the root.
   logic [c_sw-1:0]  w_node [1:2*c_np-1];
   logic [c_depth:0] r_vld;

   genvar gi;
   generate
      for (gi = 0; gi < c_np; gi++) begin : g_lane
         if (gi < SIMD) begin : g_real
            logic signed [TSrcI:0]      w_a;
            logic signed [TW:0]         w_w;
            logic signed [TSrcI+TW+1:0] w_p;
            logic        [c_sw-1:0]     r_q;

            // One extra bit turns an unsigned operand into a non-negative
            // signed one, so a single signed multiplier covers every mix.
            assign w_a = {(ACT_SIGNED != 0) ? in_act[gi*TSrcI+TSrcI-1] : 1'b0,
                          in_act[gi*TSrcI +: TSrcI]};
            assign w_w = {(WGT_SIGNED != 0) ? in_wgt[gi*TW+TW-1] : 1'b0,
                          in_wgt[gi*TW +: TW]};
            assign w_p = w_a * w_w;

            always_ff @(posedge clk) begin
               if (rst) begin
                  r_q <= '0;
               end else if (do_mvau_stream) begin
                  r_q <= c_sw'(w_p);
               end
            end
            assign w_node[c_np+gi] = r_q;
         end else begin : g_pad
            assign w_node[c_np+gi] = '0;
         end
      end

      for (gi = 1; gi < c_np; gi++) begin : g_node
         logic [c_sw-1:0] r_q;
         always_ff @(posedge clk) begin
            if (rst) begin
               r_q <= '0;
            end else if (do_mvau_stream) begin
               r_q <= w_node[2*gi] + w_node[2*gi+1];
            end
         end
         assign w_node[gi] = r_q;
      end
   endgenerate

   // Valid bit follows the data through the product stage and each tree level.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld <= '0;
      end else if (do_mvau_stream) begin
         for (int l = c_depth; l > 0; l--) begin
            r_vld[l] <= r_vld[l-1];
         end
         r_vld[0] <= in_v;
      end
   end

   logic                    w_tv;
   logic [c_cw-1:0]         r_cnt;
   logic [TDstI-1:0]        r_acc;
   logic signed [c_aw-1:0]  w_sum_x;
   logic signed [c_aw-1:0]  w_acc_x;
   logic signed [c_aw-1:0]  w_total;
   logic [TDstI-1:0]        w_res;
   logic [TDstI-1:0]        w_acc_next;

   assign w_tv = r_vld[c_depth];

`ifdef MVU_PE_SIMD_SAT_EN
   localparam logic signed [c_aw-1:0] c_smax =
      $signed({{(c_aw-TDstI+1){1'b0}}, {(TDstI-1){1'b1}}});
   localparam logic signed [c_aw-1:0] c_smin =
      $signed({{(c_aw-TDstI+1){1'b1}}, {(TDstI-1){1'b0}}});
   localparam logic signed [c_aw-1:0] c_umax =
      $signed({{(c_aw-TDstI){1'b0}}, {TDstI{1'b1}}});
   logic w_clamp;
`endif

   always_comb begin
      if (c_sgn) begin
         w_sum_x = c_aw'($signed(w_node[1]));
         w_acc_x = c_aw'($signed(r_acc));
      end else begin
         w_sum_x = c_aw'($unsigned(w_node[1]));
         w_acc_x = c_aw'($unsigned(r_acc));
      end
      // First beat of a fold loads instead of adding.
      if (r_cnt == '0) begin
         w_acc_x = '0;
      end
      w_total = w_acc_x + w_sum_x;
      w_res   = w_total[TDstI-1:0];
`ifdef MVU_PE_SIMD_SAT_EN
      w_clamp = 1'b0;
      if (c_sgn) begin
         if (w_total > c_smax) begin
            w_res   = c_smax[TDstI-1:0];
            w_clamp = 1'b1;
         end else if (w_total < c_smin) begin
            w_res   = c_smin[TDstI-1:0];
            w_clamp = 1'b1;
         end
      end else if (w_total > c_umax) begin
         w_res   = c_umax[TDstI-1:0];
         w_clamp = 1'b1;
      end
`endif
      w_acc_next = w_tv ? w_res : r_acc;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
         r_acc <= '0;
         out   <= '0;
         out_v <= 1'b0;
      end else if (do_mvau_stream) begin
         out   <= w_acc_next;
         out_v <= w_tv && (r_cnt == c_last);
         if (w_tv) begin
            r_acc <= w_res;
            r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + c_cw'(1);
         end
      end
   end

`ifdef MVU_PE_SIMD_SAT_EN
   logic r_sat_acc;
   logic w_sat_fold;

   // Sticky clamp flag for the fold in progress, restarted on its first beat.
   assign w_sat_fold = w_clamp || ((r_cnt != '0) && r_sat_acc);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sat_acc <= 1'b0;
         out_sat   <= 1'b0;
      end else if (do_mvau_stream) begin
         out_sat <= w_tv && (r_cnt == c_last) && w_sat_fold;
         if (w_tv) begin
            r_sat_acc <= w_sat_fold;
         end
      end
   end
`else
   assign out_sat = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mvu_pe_simd_dot.sv
`default_nettype none
// ============================================================================
// Module   : tb_mvu_pe_simd_dot
// Purpose  : Self-checking bench for mvu_pe_simd_dot. Four instances cover
//            SIMD=4/SF=2 signed, SIMD=1 mixed-sign, an 8-bit accumulator
//            (saturation behaviour follows MVU_PE_SIMD_SAT_EN) and SIMD=3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mvu_pe_simd_dot;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en  = 1'b1;

   always #5 clk = ~clk;

   // Instance A: SIMD=4, SF=2, signed x signed, 16-bit result
   logic        va = 1'b0;
   logic [15:0] acta = '0, wgta = '0;
   logic        ova, sa;
   logic [15:0] oa;
   // Instance B: SIMD=1, SF=1, unsigned act x signed weight
   logic        vb = 1'b0;
   logic [3:0]  actb = '0, wgtb = '0;
   logic        ovb, sb;
   logic [15:0] ob;
   // Instance C: SIMD=4, SF=1, 8-bit result
   logic        vc = 1'b0;
   logic [15:0] actc = '0, wgtc = '0;
   logic        ovc, sc;
   logic [7:0]  oc;
   // Instance D: SIMD=3, SF=1
   logic        vd = 1'b0;
   logic [11:0] actd = '0, wgtd = '0;
   logic        ovd, sd;
   logic [15:0] od;

   mvu_pe_simd_dot #(.SIMD(4), .TSrcI(4), .TW(4), .TDstI(16), .SF(2),
                     .ACT_SIGNED(1), .WGT_SIGNED(1)) u_a (
      .clk(clk), .rst(rst), .do_mvau_stream(en), .in_v(va),
      .in_act(acta), .in_wgt(wgta), .out_v(ova), .out(oa), .out_sat(sa));

   mvu_pe_simd_dot #(.SIMD(1), .TSrcI(4), .TW(4), .TDstI(16), .SF(1),
                     .ACT_SIGNED(0), .WGT_SIGNED(1)) u_b (
      .clk(clk), .rst(rst), .do_mvau_stream(en), .in_v(vb),
      .in_act(actb), .in_wgt(wgtb), .out_v(ovb), .out(ob), .out_sat(sb));

   mvu_pe_simd_dot #(.SIMD(4), .TSrcI(4), .TW(4), .TDstI(8), .SF(1),
                     .ACT_SIGNED(1), .WGT_SIGNED(1)) u_c (
      .clk(clk), .rst(rst), .do_mvau_stream(en), .in_v(vc),
      .in_act(actc), .in_wgt(wgtc), .out_v(ovc), .out(oc), .out_sat(sc));

   mvu_pe_simd_dot #(.SIMD(3), .TSrcI(4), .TW(4), .TDstI(16), .SF(1),
                     .ACT_SIGNED(1), .WGT_SIGNED(1)) u_d (
      .clk(clk), .rst(rst), .do_mvau_stream(en), .in_v(vd),
      .in_act(actd), .in_wgt(wgtd), .out_v(ovd), .out(od), .out_sat(sd));

   int errors = 0;
   int checks = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
      end
   endtask

   // Observe one instance for max_t samples; sample 0 is the current one.
   task automatic watch(input int which, input int max_t, output int first_t,
                        output int hits, output logic [15:0] val, output logic sat);
      logic        v, s;
      logic [15:0] o;
      first_t = -1; hits = 0; val = '0; sat = 1'b0;
      for (int t = 0; t < max_t; t++) begin
         if (t > 0) tick();
         case (which)
            0:       begin v = ova; o = oa;          s = sa; end
            1:       begin v = ovb; o = ob;          s = sb; end
            2:       begin v = ovc; o = {8'h00, oc}; s = sc; end
            default: begin v = ovd; o = od;          s = sd; end
         endcase
         if (v) begin
            hits++;
            if (first_t < 0) begin
               first_t = t; val = o; sat = s;
            end
         end
      end
   endtask

   // Reference dot product: plain integer sum of signed 4-bit lane products.
   function automatic int dot4(input logic [15:0] a, input logic [15:0] w);
      int s = 0;
      logic signed [3:0] x, y;
      for (int i = 0; i < 4; i++) begin
         x = a[i*4 +: 4];
         y = w[i*4 +: 4];
         s += int'(x) * int'(y);
      end
      return s;
   endfunction

   typedef struct {
      logic [15:0] a0, w0, a1, w1;
      logic [15:0] exp;
   } vec_t;

   vec_t        tbl [5];
   int          ft, nh;
   logic [15:0] val;
   logic        sat;
   logic [15:0] q [$];
   int          b, p;

   initial begin
      tbl[0] = '{16'h3333, 16'h2222, 16'hFFFF, 16'h5555, 16'h0004};  // 24 + -20
      tbl[1] = '{16'h8888, 16'h8888, 16'h8888, 16'h8888, 16'h0200};  // 256 + 256
      tbl[2] = '{16'h7777, 16'h8888, 16'h7777, 16'h8888, 16'hFE40};  // -224 * 2
      tbl[3] = '{16'h4321, 16'h1111, 16'hCDEF, 16'h2222, 16'hFFF6};  // 10 + -20
      tbl[4] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};

      // Reset state
      tick(); tick();
      check("rst_out_a",  oa,  0);
      check("rst_outv_a", ova, 0);
      check("rst_sat_a",  sa,  0);
      check("rst_outv_b", ovb, 0);
      check("rst_out_c",  oc,  0);
      check("rst_outv_d", ovd, 0);
      rst = 1'b0;

      // Two-beat folds from the table, latency 4 after the second beat
      foreach (tbl[k]) begin
         va = 1'b1; acta = tbl[k].a0; wgta = tbl[k].w0;
         tick();
         acta = tbl[k].a1; wgta = tbl[k].w1;
         tick();
         va = 1'b0;
         watch(0, 7, ft, nh, val, sat);
         check($sformatf("tbl%0d_lat", k), ft, 3);
         check($sformatf("tbl%0d_cnt", k), nh, 1);
         check($sformatf("tbl%0d_out", k), val, tbl[k].exp);
         check($sformatf("tbl%0d_sat", k), sat, 0);
      end

      // Bubble between beats and a 3-cycle stall while in flight
      va = 1'b1; acta = 16'h3333; wgta = 16'h2222;
      tick();
      va = 1'b0;
      tick();
      va = 1'b1; acta = 16'hFFFF; wgta = 16'h5555;
      tick();
      va = 1'b0;
      ft = -1; nh = 0; val = '0;
      for (int t = 0; t < 12; t++) begin
         if (t > 0) tick();
         if (ova) begin
            nh++;
            if (ft < 0) begin ft = t; val = oa; end
         end
         en = !((t + 1) >= 2 && (t + 1) <= 4);
      end
      en = 1'b1;
      check("stall_lat", ft, 6);
      check("stall_cnt", nh, 1);
      check("stall_out", val, 16'h0004);

      // SIMD=1 mixed sign: 15 * -8
      vb = 1'b1; actb = 4'hF; wgtb = 4'h8;
      tick();
      vb = 1'b0;
      watch(1, 4, ft, nh, val, sat);
      check("b_lat", ft, 1);
      check("b_out", val, 16'hFF88);
      vb = 1'b1; nh = 0;
      for (int t = 0; t < 6; t++) begin
         tick();
         if (t == 2) vb = 1'b0;
         if (ovb) nh++;
      end
      check("b_every_beat", nh, 3);

      // 8-bit accumulator, sum 196
      vc = 1'b1; actc = 16'h7777; wgtc = 16'h7777;
      tick();
      vc = 1'b0;
      watch(2, 6, ft, nh, val, sat);
      check("c_lat", ft, 3);
`ifdef MVU_PE_SIMD_SAT_EN
      check("c_out", val, 16'h007F);
      check("c_sat", sat, 1);
`else
      check("c_out", val, 16'h00C4);
      check("c_sat", sat, 0);
`endif

      // SIMD=3: 1*4 + 2*5 + 3*6
      vd = 1'b1; actd = 12'h321; wgtd = 12'h654;
      tick();
      vd = 1'b0;
      watch(3, 6, ft, nh, val, sat);
      check("d_lat", ft, 3);
      check("d_out", val, 16'd32);

      // Reset mid-fold (with enable low) discards the partial beat
      va = 1'b1; acta = 16'h3333; wgta = 16'h2222;
      tick();
      va = 1'b0; en = 1'b0; rst = 1'b1;
      tick();
      check("midrst_out",  oa,  0);
      check("midrst_outv", ova, 0);
      rst = 1'b0; en = 1'b1;
      va = 1'b1; acta = 16'h4321; wgta = 16'h1111;
      tick();
      tick();
      va = 1'b0;
      watch(0, 8, ft, nh, val, sat);
      check("midrst_lat", ft, 3);
      check("midrst_cnt", nh, 1);
      check("midrst_res", val, 16'd20);

      // Randomised stream with random stalls and bubbles
      rst = 1'b1;
      tick();
      rst = 1'b0;
      b = 0; p = 0;
      for (int c = 0; c < 400; c++) begin
         en   = ($urandom_range(0, 4) != 0);
         va   = ($urandom_range(0, 3) != 0);
         acta = 16'($urandom);
         wgta = 16'($urandom);
         if (en && va) begin
            p = (b == 0) ? dot4(acta, wgta) : p + dot4(acta, wgta);
            b++;
            if (b == 2) begin
               q.push_back(16'(p));
               b = 0;
            end
         end
         tick();
         if (en && ova) begin
            if (q.size() == 0) check("rnd_extra", ova, 0);
            else               check("rnd_out", oa, q.pop_front());
         end
      end
      en = 1'b1; va = 1'b0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (ova) begin
            if (q.size() == 0) check("rnd_extra", ova, 0);
            else               check("rnd_out", oa, q.pop_front());
         end
      end
      check("rnd_drain", q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
